// File: rtl/izhikevich_state_integrator.sv
// Izhikevich neuron state holder: integrates one dv/dw step per handshake, detects spikes,
// applies the after-spike reset and counts spikes. Optional refractory period: IZH_REFRACTORY_EN.
module izhikevich_state_integrator #(
    parameter int N = 16,
    parameter int Q = 8,
    parameter logic [N-1:0] V_THRESH = N'(32'sd30 <<< Q),
    parameter logic [N-1:0] C_RESET  = N'(-32'sd65 <<< Q),
    parameter logic [N-1:0] D_INC    = N'(32'sd8 <<< Q),
    parameter logic [N-1:0] W_INIT   = N'(32'sd0)
`ifdef IZH_REFRACTORY_EN
    ,
    parameter int REFRACT_CYCLES = 4
`endif
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] dv,
    input  logic [N-1:0] dw,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] v_out,
    output logic [N-1:0] w_out,
    output logic         spike,
    output logic [15:0]  spike_count
);

    typedef enum logic [1:0] {IDLE, INTEG, CHECK, HOLD} state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [N-1:0]  r_v;
    logic [N-1:0]  r_w;
    logic [N-1:0]  r_dv;
    logic [N-1:0]  r_dw;
    logic          r_in_ready;
    logic          r_out_valid;
    logic          r_spike;
    logic [15:0]   r_spike_count;
    logic [N-1:0]  w_v_sum;
    logic [N-1:0]  w_v_step;
    logic [N-1:0]  w_w_sum;
    logic [N-1:0]  w_w_spike;
    logic          w_fire;

    // Signed add at N+1 bits, clamped to the most positive / most negative word.
    function automatic logic [N-1:0] sat_add(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N:0] sum;
        sum = {a[N-1], a} + {b[N-1], b};
        if (sum[N] != sum[N-1]) begin
            sat_add = sum[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end else begin
            sat_add = sum[N-1:0];
        end
    endfunction

    assign w_v_sum   = sat_add(r_v, r_dv);
    assign w_w_sum   = sat_add(r_w, r_dw);
    assign w_w_spike = sat_add(r_w, D_INC);

`ifdef IZH_REFRACTORY_EN
    logic [15:0] r_refract;

    // While refractory, v is frozen and threshold crossings are ignored.
    assign w_v_step = (r_refract != 16'd0) ? r_v : w_v_sum;
    assign w_fire   = ($signed(r_v) >= $signed(V_THRESH)) && (r_refract == 16'd0);

    // Refractory counter: loaded by a spike, counted down once per INTEG.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_refract <= 16'd0;
        end else if (r_state == INTEG && r_refract != 16'd0) begin
            r_refract <= r_refract - 16'd1;
        end else if (r_state == CHECK && w_fire) begin
            r_refract <= 16'(REFRACT_CYCLES);
        end else begin
            r_refract <= r_refract;
        end
    end
`else
    assign w_v_step = w_v_sum;
    assign w_fire   = ($signed(r_v) >= $signed(V_THRESH));
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: one capture, one integrate, one check, then hold for the consumer.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    w_state_next = in_valid ? INTEG : IDLE;
            INTEG:   w_state_next = CHECK;
            CHECK:   w_state_next = HOLD;
            HOLD:    w_state_next = out_ready ? IDLE : HOLD;
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v           <= C_RESET;
            r_w           <= W_INIT;
            r_dv          <= {N{1'b0}};
            r_dw          <= {N{1'b0}};
            r_in_ready    <= 1'b1;
            r_out_valid   <= 1'b0;
            r_spike       <= 1'b0;
            r_spike_count <= 16'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_dv       <= dv;
                        r_dw       <= dw;
                        r_in_ready <= 1'b0;
                    end
                end
                INTEG: begin
                    r_v <= w_v_step;
                    r_w <= w_w_sum;
                end
                CHECK: begin
                    if (w_fire) begin
                        r_v           <= C_RESET;
                        r_w           <= w_w_spike;
                        r_spike       <= 1'b1;
                        r_spike_count <= r_spike_count + 16'd1;
                    end else begin
                        r_spike <= 1'b0;
                    end
                    r_out_valid <= 1'b1;
                end
                HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_spike     <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_spike     <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign v_out       = r_v;
    assign w_out       = r_w;
    assign spike       = r_spike;
    assign spike_count = r_spike_count;

endmodule

// File: tb/tb_izhikevich_state_integrator.sv
// Self-checking bench for izhikevich_state_integrator: transaction-level model of the neuron
// update, per-cycle output comparison, directed boundary cases and a randomized phase.
module tb_izhikevich_state_integrator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dv;
    logic [15:0] dw;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] v_out;
    logic [15:0] w_out;
    logic        spike;
    logic [15:0] spike_count;

    int checks = 0;
    int errors = 0;

    // model state (plain signed integers)
    int exp_v;
    int exp_w;
    int exp_count;
    bit exp_spike;
`ifdef IZH_REFRACTORY_EN
    int m_refract;
`endif
    bit busy;

    logic [15:0] seen_v, seen_w, seen_cnt;
    logic        seen_spike;

    izhikevich_state_integrator dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .dv(dv), .dw(dw), .out_valid(out_valid), .out_ready(out_ready),
        .v_out(v_out), .w_out(w_out), .spike(spike), .spike_count(spike_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat16(input int x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    task automatic model_reset();
        exp_v = -65 * 256;
        exp_w = 0;
        exp_count = 0;
        exp_spike = 1'b0;
`ifdef IZH_REFRACTORY_EN
        m_refract = 0;
`endif
    endtask

    task automatic model_step(input logic [15:0] a_dv, input logic [15:0] a_dw);
        int  sdv;
        int  sdw;
        bit  fire;
        sdv = int'($signed(a_dv));
        sdw = int'($signed(a_dw));
`ifdef IZH_REFRACTORY_EN
        if (m_refract > 0) begin
            m_refract = m_refract - 1;
            sdv = 0;
        end
`endif
        exp_v = sat16(exp_v + sdv);
        exp_w = sat16(exp_w + sdw);
        fire = (exp_v >= 30 * 256);
`ifdef IZH_REFRACTORY_EN
        if (m_refract > 0) fire = 1'b0;
`endif
        if (fire) begin
            exp_v = -65 * 256;
            exp_w = sat16(exp_w + 8 * 256);
            exp_count = (exp_count + 1) % 65536;
`ifdef IZH_REFRACTORY_EN
            m_refract = 4;
`endif
        end
        exp_spike = fire;
    endtask

    // Per-cycle comparison whenever the outputs are settled (idle or presenting a result).
    always @(posedge clk) begin
        #2;
        if (!rst && !busy) begin
            chk("v_out", {16'd0, v_out}, {16'd0, 16'(exp_v)});
            chk("w_out", {16'd0, w_out}, {16'd0, 16'(exp_w)});
            chk("spike_count", {16'd0, spike_count}, {16'd0, 16'(exp_count)});
            if (out_valid) begin
                chk("hold_spike", {31'd0, spike}, {31'd0, exp_spike});
                chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            end else begin
                chk("idle_spike", {31'd0, spike}, 32'd0);
                chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
            end
        end
    end

    task automatic do_update(input logic [15:0] a_dv, input logic [15:0] a_dw,
                             input int hold, input bit early, input bit poke);
        int n;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("wait_in_ready", {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        dv        = a_dv;
        dw        = a_dw;
        out_ready = early;
        busy      = 1'b1;
        model_step(a_dv, a_dw);
        @(negedge clk);
        in_valid = 1'b0;
        dv = 16'($urandom);
        dw = 16'($urandom);
        chk("lat_t0", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("lat_t1", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("lat_t2", {31'd0, out_valid}, 32'd1);
        seen_v = v_out; seen_w = w_out; seen_spike = spike; seen_cnt = spike_count;
        busy = 1'b0;
        if (!early) begin
            for (int i = 0; i < hold; i++) begin
                if (poke) begin
                    in_valid = 1'b1;
                    dv = 16'($urandom);
                    dw = 16'($urandom);
                end
                @(negedge clk);
                chk("bp_valid", {31'd0, out_valid}, 32'd1);
                chk("bp_v_stable", {16'd0, v_out}, {16'd0, seen_v});
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(negedge clk);
        chk("release_valid", {31'd0, out_valid}, 32'd0);
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] pre;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dv = 16'd0; dw = 16'd0;
        busy = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_v", {16'd0, v_out}, 32'h0000BF00);
        chk("rst_w", {16'd0, w_out}, 32'h00000000);
        chk("rst_cnt", {16'd0, spike_count}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_spike", {31'd0, spike}, 32'd0);
        rst = 1'b0;
        busy = 1'b0;

        // first step from the reset state: -65.0 + 1.0
        do_update(16'h0100, 16'h0000, 2, 1'b0, 1'b0);
        chk("t1_v", {16'd0, seen_v}, 32'h0000C000);
        chk("t1_spike", {31'd0, seen_spike}, 32'd0);
        chk("t1_cnt", {16'd0, seen_cnt}, 32'd0);

        // reach +29.0, then exactly +30.0 fires
        do_update(16'h5D00, 16'h0000, 0, 1'b1, 1'b0);
        chk("t2_pre_v", {16'd0, seen_v}, 32'h00001D00);
        do_update(16'h0100, 16'h0000, 1, 1'b0, 1'b0);
        chk("t2_spike", {31'd0, seen_spike}, 32'd1);
        chk("t2_v", {16'd0, seen_v}, 32'h0000BF00);
        chk("t2_w", {16'd0, seen_w}, 32'h00000800);
        chk("t2_cnt", {16'd0, seen_cnt}, 32'd1);

`ifdef IZH_REFRACTORY_EN
        for (int k = 1; k <= 4; k++) begin
            do_update(16'h4000, 16'h0100, 0, 1'b1, 1'b0);
            chk("ref_v_held", {16'd0, seen_v}, 32'h0000BF00);
            chk("ref_no_spike", {31'd0, seen_spike}, 32'd0);
            chk("ref_w_acc", {16'd0, seen_w}, 32'(16'h0800 + 16'(k * 256)));
        end
        do_update(16'h4000, 16'h0000, 0, 1'b1, 1'b0);
        chk("ref_fifth_v", {16'd0, seen_v}, 32'h0000FF00);
`endif

        // w clamps at the most negative value
        repeat (3) do_update(16'h0000, 16'h8000, 0, 1'b1, 1'b0);
        chk("w_clamp", {16'd0, w_out}, 32'h00008000);

        // v saturates at +max and fires
        pre = 16'(32'h1000 - exp_v);
        do_update(pre, 16'h0000, 0, 1'b1, 1'b0);
        do_update(16'h7FFF, 16'h7FFF, 0, 1'b1, 1'b0);
        chk("vsat_spike", {31'd0, seen_spike}, 32'd1);
        chk("vsat_v", {16'd0, seen_v}, 32'h0000BF00);
        chk("vsat_w", {16'd0, seen_w}, 32'h000007FF);
        chk("vsat_cnt", {16'd0, seen_cnt}, 32'd2);

        // backpressure with a competing in_valid during hold
        do_update(16'h0200, 16'h0010, 10, 1'b0, 1'b1);

        for (int it = 0; it < 200; it++) begin
            logic [15:0] rdv, rdw;
            if ($urandom_range(0, 9) == 0) rdv = 16'($urandom);
            else rdv = 16'(int'($urandom_range(0, 2560)) - 512);
            if ($urandom_range(0, 9) == 0) rdw = 16'($urandom);
            else rdw = 16'(int'($urandom_range(0, 512)) - 256);
            do_update(rdv, rdw, int'($urandom_range(0, 3)), bit'($urandom_range(0, 3) == 0),
                      bit'($urandom_range(0, 1)));
        end

        // reset while a spiking update sits in CHECK
        repeat (5) do_update(16'h0000, 16'h0000, 0, 1'b1, 1'b0);
        pre = 16'(32'h1D00 - exp_v);
        do_update(pre, 16'h0000, 0, 1'b1, 1'b0);
        @(negedge clk);
        in_valid = 1'b1; dv = 16'h0100; dw = 16'h0000; busy = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_v", {16'd0, v_out}, 32'h0000BF00);
        chk("arst_cnt", {16'd0, spike_count}, 32'd0);
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_spike", {31'd0, spike}, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        busy = 1'b0;
        repeat (4) @(negedge clk);
        chk("arst_no_valid", {31'd0, out_valid}, 32'd0);
        do_update(16'h0100, 16'h0000, 1, 1'b0, 1'b0);
        chk("post_rst_v", {16'd0, seen_v}, 32'h0000C000);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
